dlbf_coeffs_strm: RTL and testbench
===================================

// Module: dlbf_coeffs_strm
// PURPOSE
//  Reads 64-bit beamforming coefficients from port B of the coefficient BRAM.
//  The host fills that BRAM through the 32-bit AXI-BRAM bridge on port A.
//  Streams the coefficients to the AIE PLIO as AXI4-Stream, repeating one block for N iterations.
//  Reports busy/done/iteration status as a 32-bit word for the bridge's CSR read path (csr_rddata).
// PARAMETERS
//  RD_LAT      2   BRAM port-B read latency in clocks (1..3)
//  FIFO_DEPTH  8   output buffer depth in words; power of 2, >= RD_LAT+2
//  AW          16  BRAM word-address width
// PORTS
//  aclk            in   1   single clock for all logic
//  aresetn         in   1   asynchronous, active-low reset
//  ctrl_start      in   1   1-cycle pulse: begin a run
//  ctrl_stop       in   1   1-cycle pulse: end the run at the next block boundary
//  cfg_base        in   AW  first BRAM word address of the block
//  cfg_block_words in   16  words per block (tlast period)
//  cfg_num_iter    in   32  block repetitions; 0 = continuous until ctrl_stop
//  enb             out  1   BRAM port-B enable (read-only)
//  addrb           out  AW  BRAM port-B word address
//  doutb           in   64  BRAM port-B read data, valid RD_LAT clocks after enb
//  m_axis_tdata    out  64  coefficient word
//  m_axis_tvalid   out  1   stream valid
//  m_axis_tready   in   1   stream ready
//  m_axis_tlast    out  1   last word of each block
//  status          out  32  {done[31], busy[30], 14'b0, iter_cnt[15:0]} -> csr_rddata
// BEHAVIOUR
//  Reset: enb=0, addrb=0, tvalid=0, tlast=0, tdata=0, status=0, FSM=IDLE, FIFO empty.
//  FSM states:
//   IDLE  -> RUN on ctrl_start. Latches cfg_* and clears done and iter_cnt.
//         If cfg_block_words=0 at start -> DONE directly; no beats are issued.
//   RUN   issues one read per cycle while (fifo_count + reads_in_flight) < FIFO_DEPTH.
//         Word index idx runs 0..block_words-1; addrb = cfg_base+idx, mod 2^AW (wraps).
//         At the last idx of a block: idx->0 and issued_iter++.
//         Leave for DRAIN when issued_iter reaches num_iter (num_iter!=0),
//         or when a stop is pending and the block has been fully issued.
//   DRAIN no new reads; waits until reads_in_flight=0 and FIFO empty -> DONE.
//   DONE  1 cycle: done<=1 (sticky until next start), busy<=0 -> IDLE.
//  busy=1 in RUN and DRAIN.
//  ctrl_start outside IDLE is ignored.
//  ctrl_stop in RUN sets stop_pending. The current block is always completed, so tlast is never truncated.
//  ctrl_stop is ignored in IDLE and DONE.
//  Read pipeline: a RD_LAT-deep shift of {valid, last} flags tracks enb.
//   The matching doutb is written into the FIFO with its last flag.
//   The credit rule above guarantees the FIFO never overflows. No read is ever discarded.
//  Stream: tvalid = FIFO not empty; tdata/tlast come from the FIFO head.
//   Pop on tvalid&&tready. Data is held stable while tvalid&&!tready (AXI rule).
//  Throughput: 1 word/clk sustained with tready=1.
//  First-beat latency: start -> tvalid high is RD_LAT+2 clocks.
//  iter_cnt increments on each accepted tlast beat and saturates at 16'hFFFF.
//  Reset mid-run: all state clears immediately; in-flight reads are dropped; tvalid falls asynchronously.
//  Simultaneous ctrl_start and ctrl_stop in IDLE: start wins; stop is ignored.
// STRUCTURE
//  dlbf_coeffs_pkg: FSM state enum, STATUS_DONE_BIT=31, STATUS_BUSY_BIT=30, default widths.
//  Sub-module dlbf_coeffs_fifo: synchronous FIFO, 65-bit wide {last, data}, FIFO_DEPTH deep, with count output.
//  Top level holds the FSM, address/iteration counters, read-latency flag pipe and status register.
// TESTING
//  1. base=0x0010, block=4, iter=2, tready=1 -> 8 beats, data = mem[0x10..0x13] twice;
//     tlast on beats 4 and 8; status = 0x8000_0002.
//  2. Same config, tready toggling 1/0 every cycle -> identical data order.
//     No drops or duplicates; tdata is stable while stalled.
//  3. base=0xFFFE, block=4, iter=1 -> addrb sequence FFFE, FFFF, 0000, 0001.
//  4. iter=0, block=3; ctrl_stop pulsed mid-block 5 -> stream ends after block 5's tlast;
//     iter_cnt=5; done=1.
//  5. block=0 start -> no tvalid ever; done=1 within 2 clocks. Start pulsed during busy -> ignored.
//  6. aresetn asserted while FIFO full and tready=0 -> tvalid=0, status=0.
//     A fresh start after release streams from base correctly.

Source files
------------

// File: rtl/dlbf_coeffs_pkg.sv
// Shared constants for the beamforming coefficient streamer: status layout,
// default widths and FSM state encodings.
package dlbf_coeffs_pkg;

  localparam int STATUS_DONE_BIT = 31;
  localparam int STATUS_BUSY_BIT = 30;

  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_AW         = 16;
  localparam int DATA_W         = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic logic [31:0] pack_status(input logic done, input logic busy,
                                              input logic [15:0] iter_cnt);
    logic [31:0] s;
    s = '0;
    s[STATUS_DONE_BIT] = done;
    s[STATUS_BUSY_BIT] = busy;
    s[15:0]            = iter_cnt;
    return s;
  endfunction

endpackage

// File: rtl/dlbf_coeffs_strm_if.sv
// AXI4-Stream link carrying 64-bit coefficient words towards the AIE PLIO.
interface dlbf_coeffs_strm_if;
  import dlbf_coeffs_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/dlbf_coeffs_fifo.sv
// Synchronous FIFO with occupancy count; the head word is presented
// combinationally so the stream side can read it without a bubble.
module dlbf_coeffs_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; the consumer masks the head while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/dlbf_coeffs_strm.sv
// Streams one block of BRAM coefficients N times over AXI4-Stream and exposes
// busy/done/iteration status for the CSR read path.
//
// state | meaning
// IDLE  | waiting for ctrl_start, config latched on start
// RUN   | issuing BRAM reads, gated by FIFO credit
// DRAIN | no new reads, waiting for pipe and FIFO to empty
// DONE  | one cycle, sets sticky done
module dlbf_coeffs_strm
  import dlbf_coeffs_pkg::*;
#(
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AW         = DEF_AW
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                ctrl_start,
  input  logic                ctrl_stop,
  input  logic [AW-1:0]       cfg_base,
  input  logic [15:0]         cfg_block_words,
  input  logic [31:0]         cfg_num_iter,
  output logic                enb,
  output logic [AW-1:0]       addrb,
  input  logic [DATA_W-1:0]   doutb,
  dlbf_coeffs_strm_if.master  m_axis,
  output logic [31:0]         status
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 2;

  state_t            state;
  logic [AW-1:0]     base_q;
  logic [15:0]       bw_q;
  logic [31:0]       niter_q;
  logic [15:0]       idx;
  logic [31:0]       issued_iter;
  logic              stop_pending;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       iter_cnt;

  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pl;
  logic [SW-1:0]     inflight;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;

  logic              issue;
  logic              at_last;
  logic              last_iter;
  logic              pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + SW'(pv[i]);
  end

  assign at_last   = (idx == bw_q - 16'd1);
  assign last_iter = (niter_q != '0) && (issued_iter + 32'd1 == niter_q);

  // Credit counts words already in the FIFO plus reads still in the BRAM pipe,
  // so every issued read is guaranteed a slot. A pending stop holds off the
  // next block once idx is back at the boundary.
  assign issue = (state == ST_RUN) && !(stop_pending && idx == '0) &&
                 ((SW'(fifo_count) + inflight) < SW'(FIFO_DEPTH));

  assign enb   = issue;
  assign addrb = base_q + AW'(idx);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_IDLE;
      base_q       <= '0;
      bw_q         <= '0;
      niter_q      <= '0;
      idx          <= '0;
      issued_iter  <= '0;
      stop_pending <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl_start) begin
            base_q       <= cfg_base;
            bw_q         <= cfg_block_words;
            niter_q      <= cfg_num_iter;
            idx          <= '0;
            issued_iter  <= '0;
            stop_pending <= 1'b0;
            done_q       <= 1'b0;
            if (cfg_block_words == '0) begin
              state <= ST_DONE;
            end else begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (ctrl_stop) stop_pending <= 1'b1;
          if (issue) begin
            if (at_last) begin
              idx         <= '0;
              issued_iter <= issued_iter + 32'd1;
              if (last_iter) state <= ST_DRAIN;
            end else begin
              idx <= idx + 16'd1;
            end
          end else if (stop_pending && idx == '0) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (inflight == '0 && fifo_empty) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pv <= '0;
      pl <= '0;
    end else begin
      pv[0] <= issue;
      pl[0] <= issue && at_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
      end
    end
  end

  dlbf_coeffs_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (pv[RD_LAT-1]),
    .wr_data ({pl[RD_LAT-1], doutb}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign m_axis.tlast  = !fifo_empty && fifo_head[DATA_W];
  assign pop           = m_axis.tvalid && m_axis.tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      iter_cnt <= '0;
    end else if (state == ST_IDLE && ctrl_start) begin
      iter_cnt <= '0;
    end else if (pop && m_axis.tlast && iter_cnt != 16'hFFFF) begin
      iter_cnt <= iter_cnt + 16'd1;
    end
  end

  assign status = pack_status(done_q, busy_q, iter_cnt);

endmodule

// File: tb/tb_dlbf_coeffs_strm.sv
// Directed bench for dlbf_coeffs_strm: a BRAM model feeds the DUT and a
// queue-based reference of the expected read addresses and stream beats is checked every cycle.
`timescale 1ns/1ps
module tb_dlbf_coeffs_strm;
  import dlbf_coeffs_pkg::*;

  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int AW         = 16;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        ctrl_start = 1'b0;
  logic        ctrl_stop = 1'b0;
  logic [15:0] cfg_base = '0;
  logic [15:0] cfg_block_words = '0;
  logic [31:0] cfg_num_iter = '0;
  logic        enb;
  logic [15:0] addrb;
  logic [63:0] doutb;
  logic [31:0] status;

  dlbf_coeffs_strm_if m_axis();

  dlbf_coeffs_strm #(
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (AW)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .ctrl_start      (ctrl_start),
    .ctrl_stop       (ctrl_stop),
    .cfg_base        (cfg_base),
    .cfg_block_words (cfg_block_words),
    .cfg_num_iter    (cfg_num_iter),
    .enb             (enb),
    .addrb           (addrb),
    .doutb           (doutb),
    .m_axis          (m_axis),
    .status          (status)
  );

  always #5 aclk = ~aclk;

  function automatic logic [63:0] mem_val(input logic [15:0] a);
    return {a, 16'hC0EF, ~a, a ^ 16'h1234};
  endfunction

  // BRAM port B with RD_LAT clocks of read latency
  logic [63:0] rd_pipe [RD_LAT];
  always @(posedge aclk) begin
    if (enb) rd_pipe[0] <= mem_val(addrb);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign doutb = rd_pipe[RD_LAT-1];

  int n_tests = 0;
  int n_fail  = 0;

  logic [64:0] exp_beat [$];
  logic [15:0] exp_addr [$];
  logic [63:0] seen_data [$];
  logic [15:0] addr_log [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_run(input logic [15:0] base, input int bw, input int blocks);
    for (int b = 0; b < blocks; b++) begin
      for (int i = 0; i < bw; i++) begin
        logic [15:0] a;
        a = base + 16'(i);
        exp_addr.push_back(a);
        exp_beat.push_back({(i == bw - 1), mem_val(a)});
      end
    end
  endtask

  task automatic compare_loop();
    logic        prev_stall;
    logic [63:0] prev_data;
    logic [64:0] e;
    logic [15:0] ea;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_stall = 1'b0;
      end else begin
        if (enb) begin
          addr_log.push_back(addrb);
          if (exp_addr.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL read_extra: addrb %h with no read expected", addrb);
          end else begin
            ea = exp_addr.pop_front();
            check("addrb", 64'(addrb), 64'(ea));
          end
        end
        if (prev_stall) begin
          check("stall_tvalid", 64'(m_axis.tvalid), 64'd1);
          check("stall_tdata", m_axis.tdata, prev_data);
        end
        if (m_axis.tvalid && m_axis.tready) begin
          seen_data.push_back(m_axis.tdata);
          if (exp_beat.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_extra: tdata %h with no beat expected", m_axis.tdata);
          end else begin
            e = exp_beat.pop_front();
            check("tdata", m_axis.tdata, e[63:0]);
            check("tlast", 64'(m_axis.tlast), 64'(e[64]));
          end
        end
        prev_stall = m_axis.tvalid && !m_axis.tready;
        prev_data  = m_axis.tdata;
      end
    end
  endtask

  task automatic start_run(input logic [15:0] base, input logic [15:0] bw, input logic [31:0] ni);
    @(posedge aclk);
    #1;
    cfg_base        = base;
    cfg_block_words = bw;
    cfg_num_iter    = ni;
    ctrl_start      = 1'b1;
    @(posedge aclk);
    #1;
    ctrl_start = 1'b0;
  endtask

  task automatic run_until_done(input int max_cyc, input bit toggle);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(posedge aclk);
      #1;
      if (toggle) m_axis.tready = ~m_axis.tready;
      if (status[STATUS_DONE_BIT]) seen = 1'b1;
    end
    check("done_reached", 64'(seen), 64'd1);
    m_axis.tready = 1'b1;
    check("beats_left", 64'(exp_beat.size()), 64'd0);
    check("reads_left", 64'(exp_addr.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int lat;
    m_axis.tready = 1'b1;
    fork
      compare_loop();
    join_none

    #2 aresetn = 1'b0;
    #1;
    check("rst_enb", 64'(enb), 64'd0);
    check("rst_addrb", 64'(addrb), 64'd0);
    check("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis.tlast), 64'd0);
    check("rst_tdata", m_axis.tdata, 64'd0);
    check("rst_status", 64'(status), 64'd0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // two iterations of a 4-word block, full-rate sink
    k = seen_data.size();
    expect_run(16'h0010, 4, 2);
    start_run(16'h0010, 16'd4, 32'd2);
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      lat++;
      if (m_axis.tvalid) break;
    end
    check("first_beat_latency", 64'(lat), 64'(RD_LAT + 2));
    run_until_done(100, 1'b0);
    check("t1_status", 64'(status), 64'h8000_0002);
    check("t1_beat0", seen_data[k], 64'h0010_C0EF_FFEF_1224);
    check("t1_beat3", seen_data[k+3], 64'h0013_C0EF_FFEC_1227);
    check("t1_beat4", seen_data[k+4], 64'h0010_C0EF_FFEF_1224);

    // same configuration with a toggling sink
    k = seen_data.size();
    expect_run(16'h0010, 4, 2);
    start_run(16'h0010, 16'd4, 32'd2);
    run_until_done(200, 1'b1);
    check("t2_status", 64'(status), 64'h8000_0002);
    check("t2_beat7", seen_data[k+7], 64'h0013_C0EF_FFEC_1227);

    // address wrap at the top of the BRAM
    k = addr_log.size();
    expect_run(16'hFFFE, 4, 1);
    start_run(16'hFFFE, 16'd4, 32'd1);
    run_until_done(100, 1'b0);
    check("wrap_addr0", 64'(addr_log[k]),   64'h0000_FFFE);
    check("wrap_addr1", 64'(addr_log[k+1]), 64'h0000_FFFF);
    check("wrap_addr2", 64'(addr_log[k+2]), 64'h0000_0000);
    check("wrap_addr3", 64'(addr_log[k+3]), 64'h0000_0001);
    check("t3_status", 64'(status), 64'h8000_0001);

    // continuous run, stop raised while block 5 is being read
    expect_run(16'h0200, 3, 5);
    k = addr_log.size();
    start_run(16'h0200, 16'd3, 32'd0);
    for (int c = 0; c < 200; c++) begin
      @(posedge aclk);
      if (addr_log.size() - k >= 13) break;
    end
    #1 ctrl_stop = 1'b1;
    @(posedge aclk);
    #1 ctrl_stop = 1'b0;
    run_until_done(200, 1'b0);
    check("t4_status", 64'(status), 64'h8000_0005);
    check("t4_reads", 64'(addr_log.size() - k), 64'd15);

    // empty block finishes at once, no beats
    start_run(16'h0050, 16'd0, 32'd3);
    @(posedge aclk);
    #1;
    check("t5_zero_status", 64'(status), 64'h8000_0000);
    check("t5_zero_tvalid", 64'(m_axis.tvalid), 64'd0);

    // a second start while busy must be ignored
    expect_run(16'h0020, 4, 1);
    start_run(16'h0020, 16'd4, 32'd1);
    repeat (2) @(posedge aclk);
    start_run(16'h0040, 16'd2, 32'd3);
    check("t5_busy", 64'(status[STATUS_BUSY_BIT]), 64'd1);
    run_until_done(100, 1'b0);
    check("t5_status", 64'(status), 64'h8000_0001);

    // reset while the FIFO is full and the sink is stalled
    expect_run(16'h0100, 4, 3);
    k = addr_log.size();
    m_axis.tready = 1'b0;
    start_run(16'h0100, 16'd4, 32'd0);
    repeat (20) @(posedge aclk);
    #1;
    check("t6_full_tvalid", 64'(m_axis.tvalid), 64'd1);
    check("t6_full_reads", 64'(addr_log.size() - k), 64'(FIFO_DEPTH));
    check("t6_busy_status", 64'(status), 64'h4000_0000);
    aresetn = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("t6_rst_status", 64'(status), 64'd0);
    check("t6_rst_enb", 64'(enb), 64'd0);
    exp_beat.delete();
    exp_addr.delete();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    m_axis.tready = 1'b1;
    k = seen_data.size();
    expect_run(16'h0030, 2, 2);
    start_run(16'h0030, 16'd2, 32'd2);
    run_until_done(100, 1'b0);
    check("t6_status", 64'(status), 64'h8000_0002);
    check("t6_beat0", seen_data[k], 64'h0030_C0EF_FFCF_1204);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
